// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, machine word, and arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache.
// One transaction in flight; dcache wins ties unless the icache has been
// passed over STARVE_MAX times in a row. Outputs are decoded from the
// registered state plus the live RAM handshake so completion is signalled
// in the same cycle the RAM reports ACCESS.
// Optional: define MEMORY_ARBITER_STATS_EN to add icount/dcount completion
// counters.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4   // must fit the 3-bit counter
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    output word_t     icount,
    output word_t     dcount
`endif
);

    arb_state_t r_state;
    logic [2:0] r_starve;

    logic w_dreq;
    logic w_starved;
    logic w_idone;
    logic w_ddone;

    assign w_dreq    = dREN | dWEN;
    assign w_starved = (r_starve == 3'(STARVE_MAX));
    assign w_idone   = (r_state == IACC) && iREN   && (ramstate == ACCESS);
    assign w_ddone   = (r_state == DACC) && w_dreq && (ramstate == ACCESS);

    // Arbitration FSM and icache starvation counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!iREN)
                        r_starve <= '0;
                    if (w_dreq && !(iREN && w_starved)) begin
                        r_state <= DACC;
                        // never increments past STARVE_MAX: a starved icache wins
                        if (iREN)
                            r_starve <= r_starve + 3'd1;
                    end else if (iREN) begin
                        r_state  <= IACC;
                        r_starve <= '0;
                    end
                end
                // drop of request, completion or RAM error all end the access
                IACC: if (!iREN || ramstate == ACCESS || ramstate == ERROR)
                          r_state <= IDLE;
                DACC: if (!w_dreq || ramstate == ACCESS || ramstate == ERROR)
                          r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    // RAM strobes and cache responses decoded from the current grant.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (w_idone) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;   // read+write together is a write
                if (w_ddone) begin
                    dwait = 1'b0;
                    dload = dWEN ? '0 : ramload;
                end
            end
            default: ;
        endcase
    end

`ifdef MEMORY_ARBITER_STATS_EN
    // Completed-transaction counters, free-running with natural wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (w_idone) icount <= icount + 32'd1;
            if (w_ddone) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, icache read with wait states,
// starvation limit, dcache abort, RAM error retry, async reset mid-access,
// and (with MEMORY_ARBITER_STATS_EN) the completion counters.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;
`ifdef MEMORY_ARBITER_STATS_EN
    word_t     icount, dcount;
`endif

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEMORY_ARBITER_STATS_EN
        , .icount(icount), .dcount(dcount)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are applied just after the edge
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic itx(input word_t data);
        iREN = 1'b1; iaddr = 32'h10; ramstate = FREE;
        nxt();
        ramstate = ACCESS; ramload = data; #1;
        chk("itx_iwait", {31'd0, iwait}, 32'd0);
        nxt();
        iREN = 1'b0; ramstate = FREE;
    endtask

    task automatic dtx(input word_t data);
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h20; ramstate = FREE;
        nxt();
        ramstate = ACCESS; ramload = data; #1;
        chk("dtx_dload", dload, data);
        nxt();
        dREN = 1'b0; ramstate = FREE;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #2;
        chk("rst_iwait",  {31'd0, iwait},  32'd1);
        chk("rst_dwait",  {31'd0, dwait},  32'd1);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_iload",  iload, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        nxt();

        // icache read: grant, two BUSY cycles, ACCESS
        iREN = 1'b1; iaddr = 32'h40; #1;
        chk("i_idle_ramREN", {31'd0, ramREN}, 32'd0);
        nxt();
        ramstate = BUSY; #1;
        chk("i_b1_ramREN",  {31'd0, ramREN}, 32'd1);
        chk("i_b1_ramaddr", ramaddr, 32'h40);
        chk("i_b1_iwait",   {31'd0, iwait},  32'd1);
        chk("i_b1_iload",   iload, 32'd0);
        nxt(); #1;
        chk("i_b2_iwait",   {31'd0, iwait},  32'd1);
        nxt();
        ramstate = ACCESS; ramload = 32'h8C220004; #1;
        chk("i_acc_iwait",  {31'd0, iwait},  32'd0);
        chk("i_acc_iload",  iload, 32'h8C220004);
        nxt();
        iREN = 1'b0; ramstate = FREE; #1;
        chk("i_post_iwait",  {31'd0, iwait},  32'd1);
        chk("i_post_iload",  iload, 32'd0);
        chk("i_post_ramREN", {31'd0, ramREN}, 32'd0);
        nxt();

        // starvation: both requesting, four dcache writes then the icache
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100;
        dstore = 32'hDEADBEEF; ramload = 32'h12345678;
        for (int g = 0; g < 5; g++) begin
            ramstate = FREE; #1;
            chk($sformatf("s%0d_idle_wen", g), {31'd0, ramWEN}, 32'd0);
            nxt();
            for (int c = 0; c < 2; c++) begin
                ramstate = BUSY; #1;
                if (g < 4) begin
                    chk($sformatf("s%0d_c%0d_wen",  g, c), {31'd0, ramWEN}, 32'd1);
                    chk($sformatf("s%0d_c%0d_ren",  g, c), {31'd0, ramREN}, 32'd0);
                    chk($sformatf("s%0d_c%0d_addr", g, c), ramaddr, 32'h100);
                    chk($sformatf("s%0d_c%0d_st",   g, c), ramstore, 32'hDEADBEEF);
                end else begin
                    chk($sformatf("s%0d_c%0d_ren",  g, c), {31'd0, ramREN}, 32'd1);
                    chk($sformatf("s%0d_c%0d_wen",  g, c), {31'd0, ramWEN}, 32'd0);
                    chk($sformatf("s%0d_c%0d_addr", g, c), ramaddr, 32'h44);
                end
                nxt();
            end
            ramstate = ACCESS; #1;
            if (g < 4) begin
                chk($sformatf("s%0d_dwait", g), {31'd0, dwait}, 32'd0);
                chk($sformatf("s%0d_iwait", g), {31'd0, iwait}, 32'd1);
                chk($sformatf("s%0d_dload", g), dload, 32'd0);
            end else begin
                chk("s4_iwait", {31'd0, iwait}, 32'd0);
                chk("s4_dwait", {31'd0, dwait}, 32'd1);
                chk("s4_iload", iload, 32'h12345678);
            end
            nxt();
        end
        iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        nxt();

        // dcache read aborted while RAM is BUSY
        dREN = 1'b1; daddr = 32'h200; nxt();
        ramstate = BUSY; #1;
        chk("ab_ren", {31'd0, ramREN}, 32'd1);
        nxt();
        dREN = 1'b0; #1;
        chk("ab_drop_ren",   {31'd0, ramREN}, 32'd0);
        chk("ab_drop_dwait", {31'd0, dwait},  32'd1);
        nxt();
        ramstate = ACCESS; ramload = 32'hAAAA5555; #1;
        chk("ab_idle_dwait", {31'd0, dwait},  32'd1);
        chk("ab_idle_ren",   {31'd0, ramREN}, 32'd0);
        chk("ab_idle_dload", dload, 32'd0);
        nxt();
        ramstate = FREE;

        // RAM error during icache access, then retry
        iREN = 1'b1; iaddr = 32'h80; nxt();
        ramstate = ERROR; #1;
        chk("er_ren",   {31'd0, ramREN}, 32'd1);
        chk("er_iwait", {31'd0, iwait},  32'd1);
        nxt();
        ramstate = FREE; #1;
        chk("er_idle_ren",   {31'd0, ramREN}, 32'd0);
        chk("er_idle_iwait", {31'd0, iwait},  32'd1);
        nxt();
        ramstate = BUSY; #1;
        chk("er_rg_ren",   {31'd0, ramREN}, 32'd1);
        chk("er_rg_addr",  ramaddr, 32'h80);
        chk("er_rg_iwait", {31'd0, iwait},  32'd1);
        nxt();
        ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
        chk("er_acc_iwait", {31'd0, iwait}, 32'd0);
        chk("er_acc_iload", iload, 32'hCAFEF00D);
        nxt();
        iREN = 1'b0; ramstate = FREE;
        nxt();

        // asynchronous reset in the middle of an icache access
        iREN = 1'b1; iaddr = 32'h300; nxt();
        ramstate = BUSY; #1;
        chk("mr_pre_ren", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0; #1;
        chk("mr_ren",   {31'd0, ramREN}, 32'd0);
        chk("mr_iwait", {31'd0, iwait},  32'd1);
        chk("mr_addr",  ramaddr, 32'd0);
        nRST = 1'b1; iREN = 1'b0; ramstate = FREE;
        nxt();

`ifdef MEMORY_ARBITER_STATS_EN
        chk("st_i0", icount, 32'd0);
        chk("st_d0", dcount, 32'd0);
        itx(32'h1); dtx(32'h2); itx(32'h3); dtx(32'h4); itx(32'h5);
        #1;
        chk("st_i3", icount, 32'd3);
        chk("st_d2", dcount, 32'd2);
        nRST = 1'b0; #1;
        chk("st_ir", icount, 32'd0);
        chk("st_dr", dcount, 32'd0);
        nRST = 1'b1;
        nxt();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive dcache grants allowed while icache waits.
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset; one clock; reset is asynchronous and active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- iwait  out  1  low only in the icache completion cycle.
- dwait  out  1  low only in the dcache completion cycle.
- iload  out  32  read data to icache.
- dload  out  32  read data to dcache.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-003 SHALL implement FSM states IDLE, IACC, DACC; one transaction in flight at a time.
REQ-004 IDLE SHALL hold all RAM strobes low, iwait=dwait=1, ramaddr=ramstore=0.
REQ-005 In IDLE, with any request present, SHALL select the next state on the clock edge (arbitration latency: 1 cycle).
- Dcache only -> DACC.
- Icache only -> IACC.
- Both -> DACC, unless starve count == STARVE_MAX, then IACC.
REQ-006 IACC SHALL drive ramREN=1 and ramaddr=iaddr.
- On ramstate==ACCESS: iwait=0 and iload=ramload in that same cycle; next state IDLE.
REQ-007 DACC SHALL drive ramaddr=daddr, ramstore=dstore, and ramWEN=dWEN, ramREN=dREN&~dWEN.
- On ACCESS: dwait=0 and dload=ramload (read only; otherwise 0); next state IDLE.
REQ-008 dREN and dWEN both high SHALL be treated as a write.
REQ-009 Requester dropping its request mid-transaction SHALL abort: next state IDLE, its wait stays high.
REQ-010 ramstate ERROR SHALL return the FSM to IDLE with wait high; the request is re-arbitrated.
REQ-011 FREE or BUSY SHALL hold the current state and outputs.
REQ-012 Starve counter: 3 bits, saturating at STARVE_MAX.
- Increments on each DACC entry with iREN high.
- Clears on IACC entry or whenever iREN is low in IDLE.
REQ-013 iload/dload SHALL be 0 outside their completion cycles.
REQ-014 Back-to-back: completion cycle returns to IDLE; the next grant starts the following cycle, so at most 1 access per 2+ cycles.

Reset
REQ-015 On nRST low, asynchronously:
- state=IDLE, starve count=0.
- Outputs take their IDLE values (iwait=dwait=1, strobes 0, loads 0).
REQ-016 Reset mid-transaction SHALL drop RAM strobes immediately, with no completion signalled.

Configuration
REQ-017 With MEMORY_ARBITER_STATS_EN defined, SHALL add outputs icount and dcount (32 bits each).
- Each counts its completed transactions, wraps at 2^32, and resets to 0.
- Without the macro, these ports and counters SHALL NOT exist.

Structure
REQ-018 ramstate_t, word_t and the arbiter state enum SHALL live in cpu_types_pkg; STARVE_MAX is a module parameter.
REQ-019 SHALL be a single module with no sub-module; the starve counter is inline.

Verification
REQ-020 Bench SHALL cover:
- Reset -> iwait=dwait=1, ramREN=ramWEN=0.
- iREN, iaddr=0x40, ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> iwait low exactly 1 cycle with iload=0x8C220004.
- iREN+dWEN held, daddr=0x100, dstore=0xDEADBEEF, RAM ACCESS on the 3rd cycle of every grant -> 4 dcache writes then 1 icache read (STARVE_MAX=4).
- dREN dropped during DACC BUSY -> IDLE next cycle, dwait never low, no ACCESS consumed.
- ramstate=ERROR during IACC -> IDLE, then re-grant to IACC, iwait stays high until ACCESS.
- MEMORY_ARBITER_STATS_EN with 3 icache and 2 dcache completions -> icount=3, dcount=2; nRST pulse -> 0.
